// File: rtl/iram_fetch_arbiter_pkg.sv
// Shared definitions for the instruction-RAM fetch arbiter: the lane-state
// encoding, the default widths and the word returned for out-of-range fetches.
package iram_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_PEND = 2'd1,
    LANE_INFL = 2'd2
  } lane_state_e;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_PC_W      = 6;
  localparam int DEF_INS_W     = 21;
  localparam int DEF_MEM_DEPTH = 52;

  // Returned in place of memory data when a core fetches past the end of memory.
  localparam logic [DEF_INS_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/iram_fetch_arbiter_if.sv
// Bus between the cores / instruction memory and the fetch arbiter.
// master: the core-and-memory side; slave: the arbiter.
interface iram_fetch_arbiter_if
  import iram_fetch_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int PC_W      = DEF_PC_W,
  parameter int INS_W     = DEF_INS_W
);
  logic [NUM_CORES-1:0]       req;
  logic [NUM_CORES*PC_W-1:0]  pc_in;
  logic [PC_W-1:0]            mem_addr;
  logic [INS_W-1:0]           mem_rdata;
  logic [NUM_CORES-1:0]       gnt;
  logic [NUM_CORES-1:0]       ins_valid;
  logic [NUM_CORES*INS_W-1:0] ins_out;
  logic [NUM_CORES-1:0]       addr_err;

  modport master (
    output req, pc_in, mem_rdata,
    input  mem_addr, gnt, ins_valid, ins_out, addr_err
  );

  modport slave (
    input  req, pc_in, mem_rdata,
    output mem_addr, gnt, ins_valid, ins_out, addr_err
  );
endinterface

// File: rtl/iram_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer
// wins; the next pointer is the slot just after the winner.
module iram_fetch_arbiter_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_next_ptr,
  output logic             o_any
);

  // Scan N slots starting at the pointer, latching the first active one.
  always_comb begin
    int idx;
    idx        = 0;
    o_gnt      = '0;
    o_next_ptr = i_ptr;
    o_any      = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(i_ptr) + i) % N;
      if (!o_any && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_any      = 1'b1;
        o_next_ptr = PTR_W'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/iram_fetch_arbiter.sv
// Shares one instruction-memory read port among NUM_CORES cores. Each lane
// walks IDLE -> PEND -> INFL -> IDLE; one lane is granted per cycle in
// round-robin order and its word is captured on the following edge.
module iram_fetch_arbiter
  import iram_fetch_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int PC_W      = DEF_PC_W,
  parameter int INS_W     = DEF_INS_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input logic                 clk,
  input logic                 rst_n,
  iram_fetch_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  lane_state_e                r_state [NUM_CORES];
  logic [PTR_W-1:0]           r_rr_ptr;
  logic [NUM_CORES-1:0]       r_gnt;
  logic [PC_W-1:0]            r_mem_addr;
  logic [NUM_CORES-1:0]       r_ins_valid;
  logic [NUM_CORES*INS_W-1:0] r_ins_out;
  logic [NUM_CORES-1:0]       r_addr_err;

  logic [NUM_CORES-1:0]       w_pend_mask;
  logic [NUM_CORES-1:0]       w_infl_mask;
  logic [NUM_CORES-1:0]       w_gnt;
  logic [PTR_W-1:0]           w_next_ptr;
  logic                       w_any_gnt;
  logic [PC_W-1:0]            w_gnt_pc;
  logic                       w_addr_oor;
  logic [INS_W-1:0]           w_cap_word;

  // Only lanes still requesting in PEND compete; INFL lanes are excluded by construction.
  always_comb begin
    w_pend_mask = '0;
    w_infl_mask = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_pend_mask[k] = (r_state[k] == LANE_PEND) && bus.req[k];
      w_infl_mask[k] = (r_state[k] == LANE_INFL);
    end
  end

  iram_fetch_arbiter_rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req      (w_pend_mask),
    .i_ptr      (r_rr_ptr),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_next_ptr),
    .o_any      (w_any_gnt)
  );

  // Select the PC of the winning lane (grant is one-hot).
  always_comb begin
    w_gnt_pc = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (w_gnt[k]) w_gnt_pc = bus.pc_in[k*PC_W +: PC_W];
    end
  end

  // mem_addr still holds the in-flight lane's PC during its capture cycle.
  always_comb begin
    w_addr_oor = (int'(r_mem_addr) >= MEM_DEPTH);
    w_cap_word = w_addr_oor ? INS_W'(NOP_WORD) : bus.mem_rdata;
  end

  // Lane FSMs, round-robin pointer and the registered grant/address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CORES; k++) r_state[k] <= LANE_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_mem_addr <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        case (r_state[k])
          LANE_IDLE: if (bus.req[k]) r_state[k] <= LANE_PEND;
          LANE_PEND: begin
            if (!bus.req[k])  r_state[k] <= LANE_IDLE;
            else if (w_gnt[k]) r_state[k] <= LANE_INFL;
          end
          LANE_INFL: r_state[k] <= LANE_IDLE;
          default:   r_state[k] <= LANE_IDLE;
        endcase
      end
      r_gnt <= w_gnt;
      if (w_any_gnt) begin
        r_mem_addr <= w_gnt_pc;
        r_rr_ptr   <= w_next_ptr;
      end
    end
  end

  // Capture returned words into the in-flight lane's slot and track bad addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_valid <= '0;
      r_ins_out   <= '0;
      r_addr_err  <= '0;
    end else begin
      r_ins_valid <= w_infl_mask;
      for (int k = 0; k < NUM_CORES; k++) begin
        if (w_infl_mask[k]) begin
          r_ins_out[k*INS_W +: INS_W] <= w_cap_word;
          if (w_addr_oor) r_addr_err[k] <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.gnt       = r_gnt;
  assign bus.ins_valid = r_ins_valid;
  assign bus.ins_out   = r_ins_out;
  assign bus.addr_err  = r_addr_err;

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed bench for iram_fetch_arbiter: single fetch, four-way round robin,
// fairness, out-of-range PC, back-to-back fetches and reset mid-flight.
module tb_iram_fetch_arbiter;
  import iram_fetch_arbiter_pkg::*;

  localparam int NC    = 4;
  localparam int PW    = 6;
  localparam int IW    = 21;
  localparam int DEPTH = 52;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  iram_fetch_arbiter_if #(.NUM_CORES(NC), .PC_W(PW), .INS_W(IW)) bus ();

  iram_fetch_arbiter #(
    .NUM_CORES (NC),
    .PC_W      (PW),
    .INS_W     (IW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word 0 = 21'h061000, word a = {a, 15'h0ABC};
  // beyond the end it returns all ones so forced-zero capture is visible.
  always_comb begin
    if (int'(bus.mem_addr) >= DEPTH)  bus.mem_rdata = 21'h1FFFFF;
    else if (bus.mem_addr == 6'd0)    bus.mem_rdata = 21'h061000;
    else                              bus.mem_rdata = {bus.mem_addr, 15'h0ABC};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] slot(input int k);
    return bus.ins_out[k*IW +: IW];
  endfunction

  task automatic set_pc(input int k, input logic [PW-1:0] pc);
    bus.pc_in[k*PW +: PW] = pc;
  endtask

  logic [3:0] fair_g [7] = '{4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 4'b0000};
  logic [3:0] fair_v [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000, 4'b0001, 4'b0100};

  initial begin
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.pc_in = '0;
    tick(); tick();

    // Reset state
    chk("rst_mem_addr",  bus.mem_addr,  6'd0);
    chk("rst_gnt",       bus.gnt,       4'b0000);
    chk("rst_ins_valid", bus.ins_valid, 4'b0000);
    chk("rst_ins_out",   bus.ins_out,   84'd0);
    chk("rst_addr_err",  bus.addr_err,  4'b0000);
    rst_n = 1'b1;
    tick();

    // Single fetch: core0, pc 0
    set_pc(0, 6'd0);
    bus.req = 4'b0001;
    tick();
    chk("single_e1_gnt", bus.gnt, 4'b0000);
    chk("single_e1_vld", bus.ins_valid, 4'b0000);
    tick();
    chk("single_e2_gnt",  bus.gnt, 4'b0001);
    chk("single_e2_addr", bus.mem_addr, 6'd0);
    chk("single_e2_vld",  bus.ins_valid, 4'b0000);
    tick();
    chk("single_e3_vld", bus.ins_valid, 4'b0001);
    chk("single_e3_ins", slot(0), 21'h061000);
    chk("single_e3_gnt", bus.gnt, 4'b0000);
    bus.req = 4'b0000;
    tick();
    chk("single_e4_vld",  bus.ins_valid, 4'b0000);
    chk("single_e4_hold", slot(0), 21'h061000);

    // Four simultaneous requests after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NC; k++) set_pc(k, PW'(k));
    bus.req = 4'b1111;
    tick();
    chk("rr4_e1_gnt", bus.gnt, 4'b0000);
    tick();
    chk("rr4_e2_gnt",  bus.gnt, 4'b0001);
    chk("rr4_e2_addr", bus.mem_addr, 6'd0);
    tick();
    chk("rr4_e3_gnt",  bus.gnt, 4'b0010);
    chk("rr4_e3_addr", bus.mem_addr, 6'd1);
    chk("rr4_e3_vld",  bus.ins_valid, 4'b0001);
    chk("rr4_e3_ins0", slot(0), 21'h061000);
    bus.req[0] = 1'b0;
    tick();
    chk("rr4_e4_gnt",  bus.gnt, 4'b0100);
    chk("rr4_e4_addr", bus.mem_addr, 6'd2);
    chk("rr4_e4_vld",  bus.ins_valid, 4'b0010);
    chk("rr4_e4_ins1", slot(1), 21'h008ABC);
    bus.req[1] = 1'b0;
    tick();
    chk("rr4_e5_gnt",  bus.gnt, 4'b1000);
    chk("rr4_e5_addr", bus.mem_addr, 6'd3);
    chk("rr4_e5_vld",  bus.ins_valid, 4'b0100);
    chk("rr4_e5_ins2", slot(2), 21'h010ABC);
    bus.req[2] = 1'b0;
    tick();
    chk("rr4_e6_gnt",  bus.gnt, 4'b0000);
    chk("rr4_e6_vld",  bus.ins_valid, 4'b1000);
    chk("rr4_e6_ins3", slot(3), 21'h018ABC);
    chk("rr4_e6_ins0", slot(0), 21'h061000);
    bus.req[3] = 1'b0;
    tick();
    chk("rr4_e7_vld", bus.ins_valid, 4'b0000);

    // Fairness: core0 and core2 hold req; pointer back at 0 so core0 goes first
    set_pc(0, 6'd0);
    set_pc(2, 6'd2);
    bus.req = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("fair_e%0d_gnt", i + 1), bus.gnt, fair_g[i]);
      chk($sformatf("fair_e%0d_vld", i + 1), bus.ins_valid, fair_v[i]);
    end
    bus.req = 4'b0000;
    tick();
    chk("fair_drop_gnt", bus.gnt, 4'b0000);
    tick();
    chk("fair_drop_vld",  bus.ins_valid, 4'b0000);
    chk("fair_drop_gnt2", bus.gnt, 4'b0000);
    chk("fair_ins2",      slot(2), 21'h010ABC);

    // Out-of-range PC on core1
    set_pc(1, 6'd60);
    bus.req = 4'b0010;
    tick();
    chk("oor_e1_err", bus.addr_err, 4'b0000);
    tick();
    chk("oor_e2_gnt",  bus.gnt, 4'b0010);
    chk("oor_e2_addr", bus.mem_addr, 6'd60);
    tick();
    chk("oor_e3_vld", bus.ins_valid, 4'b0010);
    chk("oor_e3_ins", slot(1), 21'h000000);
    chk("oor_e3_err", bus.addr_err, 4'b0010);
    bus.req = 4'b0000;
    tick();

    // Back-to-back fetches on core3 with pc 5, 6, 7
    set_pc(3, 6'd5);
    bus.req = 4'b1000;
    tick();
    tick();
    chk("b2b_a_gnt",  bus.gnt, 4'b1000);
    chk("b2b_a_addr", bus.mem_addr, 6'd5);
    tick();
    chk("b2b_a_vld", bus.ins_valid, 4'b1000);
    chk("b2b_a_ins", slot(3), 21'h028ABC);
    chk("b2b_a_nodup", bus.gnt, 4'b0000);
    set_pc(3, 6'd6);
    tick();
    chk("b2b_b_pend_gnt", bus.gnt, 4'b0000);
    chk("b2b_b_pend_vld", bus.ins_valid, 4'b0000);
    tick();
    chk("b2b_b_gnt",  bus.gnt, 4'b1000);
    chk("b2b_b_addr", bus.mem_addr, 6'd6);
    tick();
    chk("b2b_b_vld",   bus.ins_valid, 4'b1000);
    chk("b2b_b_ins",   slot(3), 21'h030ABC);
    chk("b2b_b_nodup", bus.gnt, 4'b0000);
    set_pc(3, 6'd7);
    tick();
    tick();
    chk("b2b_c_gnt",  bus.gnt, 4'b1000);
    chk("b2b_c_addr", bus.mem_addr, 6'd7);
    tick();
    chk("b2b_c_vld", bus.ins_valid, 4'b1000);
    chk("b2b_c_ins", slot(3), 21'h038ABC);
    bus.req = 4'b0000;
    tick();
    chk("b2b_err_sticky", bus.addr_err, 4'b0010);
    chk("b2b_ins1_hold",  slot(1), 21'h000000);

    // Reset the cycle after a grant to core2
    set_pc(2, 6'd4);
    bus.req = 4'b0100;
    tick();
    tick();
    chk("rmid_gnt", bus.gnt, 4'b0100);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    chk("rmid_async_gnt",  bus.gnt, 4'b0000);
    chk("rmid_async_addr", bus.mem_addr, 6'd0);
    chk("rmid_async_ins",  bus.ins_out, 84'd0);
    chk("rmid_async_err",  bus.addr_err, 4'b0000);
    tick();
    chk("rmid_no_vld", bus.ins_valid, 4'b0000);
    rst_n = 1'b1;
    set_pc(1, 6'd1);
    set_pc(3, 6'd3);
    bus.req = 4'b1010;
    tick();
    chk("rmid_e1_vld", bus.ins_valid, 4'b0000);
    tick();
    chk("rmid_e2_gnt",  bus.gnt, 4'b0010);
    chk("rmid_e2_addr", bus.mem_addr, 6'd1);
    tick();
    chk("rmid_e3_gnt", bus.gnt, 4'b1000);
    chk("rmid_e3_vld", bus.ins_valid, 4'b0010);
    chk("rmid_e3_ins", slot(1), 21'h008ABC);
    bus.req[1] = 1'b0;
    tick();
    chk("rmid_e4_vld", bus.ins_valid, 4'b1000);
    chk("rmid_e4_ins", slot(3), 21'h018ABC);
    bus.req = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iram_fetch_arbiter.md
Name: iram_fetch_arbiter

Overview:
- Shares one instruction-RAM read port between NUM_CORES processor cores.
- Each core raises a fetch request with its PC. The arbiter grants requests round-robin, drives one address per cycle to the instruction memory, and captures the returned word into that core's instruction register.
- Sits between the per-core PC/fetch stages and a single-read-port instruction memory.
- Lets the memory shrink from one read port per core to one shared port.

Parameters:
- NUM_CORES, 4, number of requesting cores.
- PC_W, 6, PC/address width.
- INS_W, 21, instruction word width.
- MEM_DEPTH, 52, number of valid instruction words (addresses 0..MEM_DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CORES  per-core fetch request; held high until the matching ins_valid.
- pc_in  in  NUM_CORES*PC_W  per-core PC, core k at bits [k*PC_W +: PC_W]; must stay stable while req[k] is high.
- mem_addr  out  PC_W  registered address to the instruction memory.
- mem_rdata  in  INS_W  combinational read data for mem_addr.
- gnt  out  NUM_CORES  one-hot, registered; pulses in the cycle mem_addr carries core k's PC.
- ins_valid  out  NUM_CORES  one-cycle pulse; ins_out slot k is updated this cycle.
- ins_out  out  NUM_CORES*INS_W  per-core instruction hold registers, core k at [k*INS_W +: INS_W].
- addr_err  out  NUM_CORES  sticky flag; core k requested a PC >= MEM_DEPTH.

Behaviour:
- Reset (async, rst_n=0) clears the following:
  - mem_addr=0, gnt=0, ins_valid=0, ins_out=all 0, addr_err=0.
  - Round-robin pointer rr_ptr=0.
  - All lane states set to IDLE.
- Per-lane FSM (2 bits):
  - IDLE -> PEND when req[k]=1.
  - PEND -> INFL when lane k wins arbitration.
  - INFL -> IDLE on the next cycle, when data is captured and ins_valid[k] pulses.
  - If req[k] is still high in the cycle after ins_valid[k], this is a new fetch: IDLE -> PEND again.
  - req[k] dropping while in PEND returns the lane to IDLE; no grant is issued.
- Arbitration, every cycle:
  - Among lanes in PEND, choose the first at or after rr_ptr (mod NUM_CORES).
  - On a grant to k: rr_ptr <= (k+1) mod NUM_CORES. With no grant, rr_ptr is unchanged.
  - At most one grant per cycle. A lane in INFL is never re-granted.
- Timing (T = first cycle req[k] is sampled high):
  - T+1: lane in PEND; arbitration picks it if it wins.
  - Winner gets mem_addr=pc_k and gnt[k]=1 registered on the same edge.
  - Next edge: ins_out[k] <= mem_rdata and ins_valid[k]=1.
  - Minimum latency, req high to ins_valid: 3 edges.
  - Throughput: one fetch per cycle sustained.
- Out-of-range PC (pc_k >= MEM_DEPTH):
  - Grant proceeds normally and mem_addr is driven as usual.
  - Captured word is forced to 0 instead of mem_rdata; ins_valid[k] still pulses.
  - addr_err[k] is set and stays set until reset.
- ins_out[k] holds its last value between fetches.
- Starvation bound: a PEND lane is granted within NUM_CORES cycles.
- Simultaneous events:
  - Capture for lane j and grant for lane k in the same cycle are both permitted; j≠k is guaranteed by the INFL mask.
  - req rising on a lane being captured in the same cycle is ignored; the lane re-enters PEND only on the following cycle.
- Reset mid-operation: in-flight fetches are discarded and no ins_valid is emitted.

Decomposition:
- Shared package holds:
  - Lane-state encoding: IDLE=2'd0, PEND=2'd1, INFL=2'd2.
  - Default widths PC_W, INS_W, MEM_DEPTH.
  - The zero/NOP word used for out-of-range fetches.
- One sub-module is natural: rr_arbiter. It is a parameterised round-robin picker taking request mask and pointer and returning a one-hot grant plus the next pointer. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Single fetch: core0 req, pc=0, memory holding 21'h061000 at address 0 -> gnt=4'b0001, then ins_valid=4'b0001, ins_out[0]=21'h061000; 3 edges from req to valid.
- Four simultaneous reqs, pcs 0,1,2,3, after reset -> gnt order core0, core1, core2, core3 on consecutive cycles; one ins_valid per cycle; each slot holds its own word; rr_ptr returns to 0.
- Fairness: core0 and core2 hold req continuously -> grants alternate 0,2,0,2; neither lane waits more than NUM_CORES cycles.
- Out-of-range: core1 req, pc=6'd60 -> ins_valid[1] pulses, ins_out[1]=0, addr_err=4'b0010; the flag stays set after later valid fetches.
- Back-to-back: core3 holds req with pc changed after each valid (5, 6, 7) -> three captures, each for the correct address; no duplicate grant while the lane is in INFL.
- Reset mid-flight: assert rst_n=0 the cycle after gnt[2] -> no ins_valid[2]; all outputs 0; next req from core1 is granted first since rr_ptr=0.
